// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and helpers for the multi-ported register file.
// Holds the default parameter values, the address/count width helpers and
// the packed-port index helper that decode uses for the same bus layout.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NR_REG     = 32;
    localparam int DEFAULT_NR_RD      = 4;
    localparam int DEFAULT_NR_WR      = 2;

    // Register address width; NR_REG is a power of two and at least 2.
    function automatic int addr_width(input int nr_reg);
        return (nr_reg <= 2) ? 1 : $clog2(nr_reg);
    endfunction

    // busy_cnt width: one extra bit over the address width.
    function automatic int cnt_width(input int nr_reg);
        return addr_width(nr_reg) + 1;
    endfunction

    // LSB of field 'port' in a bus built by concatenating 'width'-bit fields.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits and a registered busy count.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   sb_set, sb_addr mark one register pending (address 0 ignored)
//   clr_mask        registers written this cycle (bit 0 never set)
//   busy            registered busy vector
//   busy_cnt        registered population count of busy
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NR_REG = DEFAULT_NR_REG,
    localparam int AW    = addr_width(NR_REG),
    localparam int CW    = cnt_width(NR_REG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic [NR_REG-1:0] clr_mask,
    output logic [NR_REG-1:0] busy,
    output logic [CW-1:0]     busy_cnt
);

    logic [NR_REG-1:0] set_mask;
    logic [NR_REG-1:0] cleared;
    logic [NR_REG-1:0] busy_next;
    logic [CW-1:0]     dec_cnt;
    logic [CW-1:0]     cnt_next;

    always_comb begin
        set_mask = '0;
        if (sb_set && sb_addr != '0)
            set_mask[sb_addr] = 1'b1;

        // A set in the same cycle as a clear wins: a newer producer was issued.
        busy_next = (busy & ~clr_mask) | set_mask;

        // Only bits that actually fall count as decrements.
        cleared = busy & ~busy_next;
        dec_cnt = '0;
        for (int i = 0; i < NR_REG; i++)
            dec_cnt = dec_cnt + CW'(cleared[i]);

        // set_mask is one-hot, so at most one bit rises per cycle.
        cnt_next = busy_cnt + CW'(|(set_mask & ~busy)) - dec_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported integer register file with pending-write
// scoreboard. x0 reads zero and is never busy.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rs_addr/rs_data   NR_RD combinational read ports (packed, port k at k*W)
//   rs_busy           busy flag of each read address
//   wen/wr_addr/wr_data NR_WR write ports; highest index wins on conflict
//   sb_set/sb_addr    mark a register pending
//   busy_cnt          number of busy registers (registered)
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the cleared busy flag) to the read ports.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NR_REG     = DEFAULT_NR_REG,
    parameter int NR_RD      = DEFAULT_NR_RD,
    parameter int NR_WR      = DEFAULT_NR_WR,
    localparam int AW        = addr_width(NR_REG),
    localparam int CW        = cnt_width(NR_REG)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR_RD*AW-1:0]         rs_addr,
    output logic [NR_RD*DATA_WIDTH-1:0] rs_data,
    output logic [NR_RD-1:0]            rs_busy,
    input  logic [NR_WR-1:0]            wen,
    input  logic [NR_WR*AW-1:0]         wr_addr,
    input  logic [NR_WR*DATA_WIDTH-1:0] wr_data,
    input  logic                        sb_set,
    input  logic [AW-1:0]               sb_addr,
    output logic [CW-1:0]               busy_cnt
);

    logic [DATA_WIDTH-1:0] regs   [NR_REG];
    logic [DATA_WIDTH-1:0] wr_val [NR_REG];
    logic [NR_REG-1:0]     wr_hit;
    logic [NR_REG-1:0]     busy;

    // Per-register write decode; later ports overwrite earlier ones.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NR_REG; r++)
            wr_val[r] = '0;
        for (int j = 0; j < NR_WR; j++) begin
            if (wen[j] && wr_addr[port_lsb(j, AW) +: AW] != '0) begin
                wr_hit[wr_addr[port_lsb(j, AW) +: AW]] = 1'b1;
                wr_val[wr_addr[port_lsb(j, AW) +: AW]] =
                    wr_data[port_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    // regs[0] is only ever reset, so it holds zero and x0 reads need no mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NR_REG; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 1; r < NR_REG; r++)
                if (wr_hit[r])
                    regs[r] <= wr_val[r];
        end
    end

    regfile_scoreboard #(
        .NR_REG (NR_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .clr_mask (wr_hit),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int k = 0; k < NR_RD; k++) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_hit[rs_addr[port_lsb(k, AW) +: AW]]) begin
                rs_data[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
                    wr_val[rs_addr[port_lsb(k, AW) +: AW]];
                // The write clears busy unless a new producer is issued now.
                rs_busy[k] = sb_set && (sb_addr == rs_addr[port_lsb(k, AW) +: AW]);
            end else begin
                rs_data[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
                    regs[rs_addr[port_lsb(k, AW) +: AW]];
                rs_busy[k] = busy[rs_addr[port_lsb(k, AW) +: AW]];
            end
`else
            rs_data[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
                regs[rs_addr[port_lsb(k, AW) +: AW]];
            rs_busy[k] = busy[rs_addr[port_lsb(k, AW) +: AW]];
`endif
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expected responses tagged with the cycle they apply to;
// a monitor on the falling edge pops and compares them against the DUT.
module tb_register_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] rs_addr;
    logic [NR*DW-1:0] rs_data;
    logic [NR-1:0]    rs_busy;
    logic [NW-1:0]    wen;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic [AW:0]      busy_cnt;

    register_file_mp dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wen      (wen),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;   // 0 data, 1 busy, 2 busy_cnt
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_total++;
            case (e.kind)
                0:       act = rs_data[e.port*DW +: DW];
                1:       act = 32'(rs_busy[e.port]);
                default: act = 32'(busy_cnt);
            endcase
            if (e.cyc != cyc)
                $display("FAIL %s: check for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            else if (act !== e.val)
                $display("FAIL %s: port %0d got %h, expected %h", e.name, e.port, act, e.val);
            else
                n_pass++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen    = '0;
        sb_set = 1'b0;
    endtask

    task automatic set_rd(input int k, input int a);
        rs_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int j, input int a, input logic [31:0] d);
        wen[j]              = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*DW +: DW] = d;
    endtask

    task automatic expect_v(input int kind, input int k, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.port = k;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        rst     = 1'b1;
        rs_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        sb_addr = '0;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state
        set_rd(0, 0); set_rd(1, 1); set_rd(2, 15); set_rd(3, 31);
        for (int k = 0; k < NR; k++) begin
            expect_v(0, k, 32'h0, "rst_data");
            expect_v(1, k, 32'h0, "rst_busy");
        end
        expect_v(2, 0, 32'h0, "rst_cnt");
        step();

        // Write-port conflict on x5: port 1 wins
        wr(0, 5, 32'h1111_1111);
        wr(1, 5, 32'h2222_2222);
        set_rd(0, 5);
        expect_v(0, 0, BYP ? 32'h2222_2222 : 32'h0, "conflict_same");
        step();
        idle();
        expect_v(0, 0, 32'h2222_2222, "conflict_next");
        step();

        // x0 protection
        wr(0, 0, 32'hDEAD_BEEF);
        sb_set = 1'b1; sb_addr = 5'd0;
        set_rd(0, 0);
        expect_v(0, 0, 32'h0, "x0_data_same");
        expect_v(1, 0, 32'h0, "x0_busy_same");
        step();
        idle();
        expect_v(0, 0, 32'h0, "x0_data");
        expect_v(1, 0, 32'h0, "x0_busy");
        expect_v(2, 0, 32'h0, "x0_cnt");
        step();

        // Scoreboard set / clear on x7
        sb_set = 1'b1; sb_addr = 5'd7;
        set_rd(1, 7);
        expect_v(1, 1, 32'h0, "sb_set_same");
        step();
        idle();
        expect_v(1, 1, 32'h1, "sb_set_busy");
        expect_v(2, 0, 32'h1, "sb_set_cnt");
        step();
        wr(0, 7, 32'h77);
        sb_set = 1'b1; sb_addr = 5'd7;
        expect_v(1, 1, 32'h1, "setclr_busy_same");
        expect_v(0, 1, BYP ? 32'h77 : 32'h0, "setclr_data_same");
        step();
        idle();
        expect_v(1, 1, 32'h1, "setclr_busy");
        expect_v(2, 0, 32'h1, "setclr_cnt");
        expect_v(0, 1, 32'h77, "setclr_data");
        step();
        wr(1, 7, 32'h78);
        expect_v(1, 1, BYP ? 32'h0 : 32'h1, "clr_busy_same");
        expect_v(0, 1, BYP ? 32'h78 : 32'h77, "clr_data_same");
        step();
        idle();
        expect_v(1, 1, 32'h0, "clr_busy");
        expect_v(2, 0, 32'h0, "clr_cnt");
        expect_v(0, 1, 32'h78, "clr_data");
        step();

        // Bypass on x3 with all ports reading it
        wr(0, 3, 32'h33);
        step();
        idle();
        wr(1, 3, 32'hCAFE_0001);
        for (int k = 0; k < NR; k++) begin
            set_rd(k, 3);
            expect_v(0, k, BYP ? 32'hCAFE_0001 : 32'h33, "byp_same");
        end
        step();
        idle();
        for (int k = 0; k < NR; k++)
            expect_v(0, k, 32'hCAFE_0001, "byp_next");
        step();

        // Full scoreboard
        for (int r = 1; r < 32; r++) begin
            sb_set = 1'b1; sb_addr = AW'(r);
            step();
            expect_v(2, 0, 32'(r), "fill_cnt");
        end
        idle();
        set_rd(0, 1); set_rd(1, 31);
        expect_v(1, 0, 32'h1, "full_busy_x1");
        expect_v(1, 1, 32'h1, "full_busy_x31");
        step();
        wr(0, 1, 32'hA1);
        wr(1, 2, 32'hA2);
        step();
        idle();
        set_rd(0, 1); set_rd(1, 2); set_rd(2, 3);
        expect_v(2, 0, 32'd29, "dual_clr_cnt");
        expect_v(1, 0, 32'h0, "dual_clr_x1");
        expect_v(1, 1, 32'h0, "dual_clr_x2");
        expect_v(1, 2, 32'h1, "dual_clr_x3");
        expect_v(0, 1, 32'hA2, "dual_clr_data");
        // Re-marking an already busy register does not change the count
        sb_set = 1'b1; sb_addr = 5'd5;
        step();
        idle();
        expect_v(2, 0, 32'd29, "reset_already_busy");
        step();

        // Reset mid-write: write and sb_set in the reset cycle are lost
        wr(0, 9, 32'h99);
        sb_set = 1'b1; sb_addr = 5'd10;
        rst = 1'b1;
        set_rd(0, 1);
        expect_v(2, 0, 32'h0, "async_rst_cnt");
        expect_v(1, 0, 32'h0, "async_rst_busy");
        step();
        rst = 1'b0;
        idle();
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < NR; k++) begin
                set_rd(k, g*NR + k);
                expect_v(0, k, 32'h0, "post_rst_data");
                expect_v(1, k, 32'h0, "post_rst_busy");
            end
            expect_v(2, 0, 32'h0, "post_rst_cnt");
            step();
        end

        // Drain remaining expectations with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++)
            step();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_total++;
            $display("FAIL %s: never sampled, expected %h", e.name, e.val);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Multi-ported integer register file with an integrated pending-write scoreboard, for the dual-issue core's decode/writeback stages. It provides NR_RD combinational read ports and NR_WR synchronous write ports, with x0 hard-wired to zero. A per-register busy bit marks registers awaiting long-latency results (loads, multiply/divide). Optional same-cycle write-to-read bypass is compiled in by macro.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- NR_REG, 32, number of architectural registers; power of two, at least 2
- NR_RD, 4, number of read ports, 1..8
- NR_WR, 2, number of write ports, 1..4
- AW, $clog2(NR_REG), address width; localparam, not overridable

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- rs_addr  in  NR_RD*AW  read addresses; port k is bits [k*AW +: AW]
- rs_data  out  NR_RD*DW  read data, packed the same way (DW = DATA_WIDTH)
- rs_busy  out  NR_RD  busy flag for each read address
- wen  in  NR_WR  per-port write enable
- wr_addr  in  NR_WR*AW  write addresses
- wr_data  in  NR_WR*DW  write data
- sb_set  in  1  mark sb_addr as pending
- sb_addr  in  AW  register to mark as pending
- busy_cnt  out  AW+1  number of registers currently marked busy

## Operation
- Register 0 always reads 0 and is never busy. Writes and sb_set to address 0 are ignored.
- Writes:
  - Port j writes wr_data[j] to wr_addr[j] on the clock edge when wen[j]=1.
  - If two or more enabled ports target the same address, the highest-indexed port wins. No error is flagged.
- Scoreboard:
  - busy[r] is set on the edge when sb_set=1 and sb_addr=r.
  - busy[r] is cleared on the edge when any enabled write targets r.
  - If a set and a clear hit the same r in one cycle, the set wins, because a newer producer has been issued.
- Reads: rs_data[k] = reg[rs_addr[k]] and rs_busy[k] = busy[rs_addr[k]], both combinational.
- busy_cnt is a registered population count of busy[]. It is updated each edge by the net number of bits set minus bits cleared, and never exceeds NR_REG-1.
- Reset: all registers, all busy bits and busy_cnt go to 0 immediately while rst=1. After rst falls, all read outputs are 0 with busy flags 0 until the first write.

## Timing
- Write latency: without bypass, data written at edge N is readable from cycle N+1.
- busy is set at edge N; rs_busy reflects it from cycle N+1.
- busy_cnt is consistent with busy[] in the same cycle, with no extra lag.
- Reads have zero latency (combinational). The read path must close timing within half the core cycle budget.
- Reset asserted mid-write discards that write. A sb_set presented in the same cycle as reset is lost.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In the cycle a write is presented, a read of the same nonzero address returns that write's data.
  - If several ports write that address, the highest-indexed port's data is returned.
  - rs_busy for that address reads 0, unless sb_set targets the same address in the same cycle.
  - This removes one cycle from the writeback-to-decode path.
- Undefined: reads return only registered state, and rs_busy reflects registered busy bits. Decode must stall one extra cycle on writeback hazards.

## Structure
- Package regfile_pkg holds:
  - the default widths
  - AW and busy_cnt width helper functions
  - the port-packing index macros/functions shared with decode
- One natural sub-module, regfile_scoreboard. It owns the busy[] vector, the set/clear priority, the popcount delta and busy_cnt.
- The top level holds the storage array, write-port arbitration and read muxes, including the bypass.

## Test plan
- Reset: assert rst mid-run, then read all 32 registers -> every rs_data=0, rs_busy=0, busy_cnt=0.
- Write-port conflict:
  - Stimulus: wen=2'b11, both ports write x5, port0 data 0x1111_1111, port1 data 0x2222_2222.
  - Response: next cycle x5 reads 0x2222_2222.
- x0 protection: write 0xDEAD_BEEF to x0 and sb_set on x0 -> x0 reads 0, rs_busy=0, busy_cnt unchanged.
- Scoreboard set/clear:
  - sb_set x7 -> next cycle rs_busy=1, busy_cnt=1.
  - A write to x7 together with sb_set x7 -> busy stays 1 and busy_cnt stays 1.
  - A later write to x7 alone -> busy 0, busy_cnt 0.
- Bypass:
  - Stimulus: write 0xCAFE_0001 to x3 while reading x3 on all NR_RD ports.
  - With REGFILE_BYPASS_EN: same-cycle rs_data=0xCAFE_0001.
  - Without it: the old value is read that cycle and the new value the next cycle.
- Full scoreboard: sb_set x1..x31 over 31 cycles -> busy_cnt=31. A dual write clearing x1 and x2 -> busy_cnt=29.
